// File: rtl/wts_timer_pkg.sv
// Register map and control-bit positions shared by the timer block and the bus decoder.
package wts_timer_pkg;

   localparam logic [2:0] REG_PRESCALE = 3'd0;
   localparam logic [2:0] REG_PERIOD1  = 3'd1;
   localparam logic [2:0] REG_PERIOD2  = 3'd2;
   localparam logic [2:0] REG_CTRL     = 3'd3;
   localparam logic [2:0] REG_COUNT1   = 3'd4;
   localparam logic [2:0] REG_COUNT2   = 3'd5;
   localparam logic [2:0] REG_SEQ      = 3'd6;

   localparam int CTRL_T1_RUN     = 0;
   localparam int CTRL_T1_ONESHOT = 1;
   localparam int CTRL_T2_RUN     = 2;
   localparam int CTRL_T2_ONESHOT = 3;

endpackage

// File: rtl/wts_timer_channel.sv
// One timer channel: down-counter with terminal-count expiry, reload/one-shot and a 2-bit sequence number.
module wts_timer_channel #(
   parameter int TIMER_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               base_tick,
   input  logic [TIMER_W-1:0] period,
   input  logic               ctrl_wr,
   input  logic               run_wdata,
   input  logic               oneshot_wdata,
   input  logic               addr_clr,
   output logic [TIMER_W-1:0] cnt,
   output logic               run,
   output logic               oneshot,
   output logic [1:0]         seq_addr,
   output logic               trigger,
   output logic [1:0]         trigger_address
);

   logic expire;

   // A control write in the same cycle takes priority over the terminal count.
   assign expire = base_tick && run && (cnt == '0) && !ctrl_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt             <= '0;
         run             <= 1'b0;
         oneshot         <= 1'b0;
         seq_addr        <= 2'b00;
         trigger         <= 1'b0;
         trigger_address <= 2'b00;
      end else begin
         trigger         <= expire;
         trigger_address <= expire ? seq_addr : 2'b00;

         if (addr_clr)
            seq_addr <= 2'b00;
         else if (expire)
            seq_addr <= seq_addr + 2'd1;

         if (ctrl_wr) begin
            run     <= run_wdata;
            oneshot <= oneshot_wdata;
            if (run_wdata)
               cnt <= period;
         end else if (base_tick && run) begin
            if (cnt == '0) begin
               if (oneshot)
                  run <= 1'b0;
               else
                  cnt <= period;
            end else begin
               cnt <= cnt - TIMER_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/wts_timer_ctrl.sv
// Two-channel timer with a shared tick prescaler and a small register file.
module wts_timer_ctrl
   import wts_timer_pkg::*;
#(
   parameter int TIMER_W = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       reg_wr,
   input  logic [2:0] reg_addr,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic       timer1_trigger,
   output logic       timer2_trigger,
   output logic [1:0] timer1_address,
   output logic [1:0] timer2_address
);

   logic [TIMER_W-1:0] prescale;
   logic [TIMER_W-1:0] period1;
   logic [TIMER_W-1:0] period2;
   logic [TIMER_W-1:0] pre_cnt;
   logic [TIMER_W-1:0] cnt1;
   logic [TIMER_W-1:0] cnt2;
   logic               run1, run2, oneshot1, oneshot2;
   logic [1:0]         seq1, seq2;
   logic               wr_pre, wr_ctrl, wr_seq;
   logic               base_tick;

   assign wr_pre  = reg_wr && (reg_addr == REG_PRESCALE);
   assign wr_ctrl = reg_wr && (reg_addr == REG_CTRL);
   assign wr_seq  = reg_wr && (reg_addr == REG_SEQ);

   // Rewriting the prescaler restarts the phase, so that cycle never produces a base tick.
   assign base_tick = tick && (pre_cnt == prescale) && !wr_pre;

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale <= '0;
         period1  <= '0;
         period2  <= '0;
         pre_cnt  <= '0;
      end else begin
         if (wr_pre)
            prescale <= TIMER_W'(reg_wdata);
         if (reg_wr && (reg_addr == REG_PERIOD1))
            period1 <= TIMER_W'(reg_wdata);
         if (reg_wr && (reg_addr == REG_PERIOD2))
            period2 <= TIMER_W'(reg_wdata);

         if (wr_pre)
            pre_cnt <= '0;
         else if (tick)
            pre_cnt <= (pre_cnt == prescale) ? '0 : pre_cnt + TIMER_W'(1);
      end
   end

   wts_timer_channel #(.TIMER_W(TIMER_W)) u_timer1 (
      .clk             (clk),
      .reset           (reset),
      .base_tick       (base_tick),
      .period          (period1),
      .ctrl_wr         (wr_ctrl),
      .run_wdata       (reg_wdata[CTRL_T1_RUN]),
      .oneshot_wdata   (reg_wdata[CTRL_T1_ONESHOT]),
      .addr_clr        (wr_seq),
      .cnt             (cnt1),
      .run             (run1),
      .oneshot         (oneshot1),
      .seq_addr        (seq1),
      .trigger         (timer1_trigger),
      .trigger_address (timer1_address)
   );

   wts_timer_channel #(.TIMER_W(TIMER_W)) u_timer2 (
      .clk             (clk),
      .reset           (reset),
      .base_tick       (base_tick),
      .period          (period2),
      .ctrl_wr         (wr_ctrl),
      .run_wdata       (reg_wdata[CTRL_T2_RUN]),
      .oneshot_wdata   (reg_wdata[CTRL_T2_ONESHOT]),
      .addr_clr        (wr_seq),
      .cnt             (cnt2),
      .run             (run2),
      .oneshot         (oneshot2),
      .seq_addr        (seq2),
      .trigger         (timer2_trigger),
      .trigger_address (timer2_address)
   );

   always_comb begin
      reg_rdata = 8'h00;
      case (reg_addr)
         REG_PRESCALE: reg_rdata = 8'(prescale);
         REG_PERIOD1:  reg_rdata = 8'(period1);
         REG_PERIOD2:  reg_rdata = 8'(period2);
         REG_CTRL: begin
            reg_rdata[CTRL_T1_RUN]     = run1;
            reg_rdata[CTRL_T1_ONESHOT] = oneshot1;
            reg_rdata[CTRL_T2_RUN]     = run2;
            reg_rdata[CTRL_T2_ONESHOT] = oneshot2;
         end
         REG_COUNT1:   reg_rdata = 8'(cnt1);
         REG_COUNT2:   reg_rdata = 8'(cnt2);
         REG_SEQ:      reg_rdata = {4'b0000, seq2, seq1};
         default:      reg_rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_wts_timer_ctrl.sv
// Scenario bench for wts_timer_ctrl; expected triggers are queued with their cycle and sequence number.
module tb_wts_timer_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       reg_wr;
   logic [2:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       timer1_trigger, timer2_trigger;
   logic [1:0] timer1_address, timer2_address;

   typedef struct {
      int         cyc;
      int         ch;
      logic [1:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   w;

   always #5 clk = ~clk;

   wts_timer_ctrl #(.TIMER_W(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .tick           (tick),
      .reg_wr         (reg_wr),
      .reg_addr       (reg_addr),
      .reg_wdata      (reg_wdata),
      .reg_rdata      (reg_rdata),
      .timer1_trigger (timer1_trigger),
      .timer2_trigger (timer2_trigger),
      .timer1_address (timer1_address),
      .timer2_address (timer2_address)
   );

   task automatic push(input int c, input int ch, input logic [1:0] a);
      exp_t e;
      e.cyc  = c;
      e.ch   = ch;
      e.addr = a;
      exp_q.push_back(e);
   endtask

   // Advance one clock, then match any trigger against the queue and flag overdue entries.
   task automatic step();
      logic       tv[2];
      logic [1:0] av[2];
      int         idx;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      tv[0] = timer1_trigger;  av[0] = timer1_address;
      tv[1] = timer2_trigger;  av[1] = timer2_address;
      for (int c = 0; c < 2; c++) begin
         if (tv[c] !== 1'b0) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
               if (idx < 0 && exp_q[i].ch == c && exp_q[i].cyc == cyc) idx = i;
            n_tests++;
            if (idx < 0) begin
               n_fail++;
               $display("FAIL unexpected_trigger ch%0d cyc %0d: got trigger=%b, required 0", c + 1, cyc, tv[c]);
            end else begin
               if (av[c] !== exp_q[idx].addr) begin
                  n_fail++;
                  $display("FAIL trigger_address ch%0d cyc %0d: got %0d, required %0d",
                           c + 1, cyc, av[c], exp_q[idx].addr);
               end
               exp_q.delete(idx);
            end
         end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_trigger ch%0d cyc %0d: got none, required addr %0d",
                     exp_q[i].ch + 1, exp_q[i].cyc, exp_q[i].addr);
            exp_q.delete(i);
         end
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      reg_wr    = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      step();
      reg_wr    = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) step();
      n_tests++;
      if ({timer1_trigger, timer2_trigger, timer1_address, timer2_address} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, required 000000",
                  {timer1_trigger, timer2_trigger, timer1_address, timer2_address});
      end
      reg_wr = 1'b0;
      for (int a = 0; a < 8; a++) begin
         reg_addr = 3'(a);
         #1;
         n_tests++;
         if (reg_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h, required 00", a, reg_rdata);
         end
      end
      reset = 1'b0;
      tick  = 1'b0;
      step();
   endtask

   task automatic test_periodic();
      wr(3'd0, 8'd0);
      wr(3'd1, 8'd3);
      wr(3'd3, 8'h01);
      w = cyc;
      for (int k = 1; k <= 5; k++) push(w + 4 * k, 0, 2'((k - 1) % 4));
      tick = 1'b1;
      while (cyc < w + 20) step();
      reg_addr = 3'd6; #1;
      n_tests++;
      if (reg_rdata !== 8'h01) begin
         n_fail++;
         $display("FAIL periodic_seq: got %h, required 01", reg_rdata);
      end
      wr(3'd3, 8'h00);
      tick = 1'b0;
      reg_addr = 3'd4; #1;
      n_tests++;
      if (reg_rdata !== 8'd3) begin
         n_fail++;
         $display("FAIL periodic_stop_hold: got %0d, required 3", reg_rdata);
      end
   endtask

   task automatic test_oneshot();
      wr(3'd6, 8'h00);
      wr(3'd0, 8'd2);
      wr(3'd2, 8'd1);
      wr(3'd3, 8'h0C);
      w = cyc;
      push(w + 6, 1, 2'd0);
      tick = 1'b1;
      while (cyc < w + 14) step();
      tick = 1'b0;
      reg_addr = 3'd3; #1;
      n_tests++;
      if (reg_rdata !== 8'h08) begin
         n_fail++;
         $display("FAIL oneshot_ctrl: got %h, required 08", reg_rdata);
      end
      reg_addr = 3'd5; #1;
      n_tests++;
      if (reg_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL oneshot_count: got %h, required 00", reg_rdata);
      end
      reg_addr = 3'd6; #1;
      n_tests++;
      if (reg_rdata !== 8'h04) begin
         n_fail++;
         $display("FAIL oneshot_seq: got %h, required 04", reg_rdata);
      end
   endtask

   task automatic test_ctrl_collision();
      wr(3'd0, 8'd0);
      wr(3'd6, 8'h00);
      wr(3'd1, 8'd3);
      wr(3'd3, 8'h01);
      tick = 1'b1;
      repeat (3) step();
      reg_addr = 3'd4; #1;
      n_tests++;
      if (reg_rdata !== 8'd0) begin
         n_fail++;
         $display("FAIL collision_pre_count: got %0d, required 0", reg_rdata);
      end
      wr(3'd3, 8'h00);
      reg_addr = 3'd4; #1;
      n_tests++;
      if (reg_rdata !== 8'd0) begin
         n_fail++;
         $display("FAIL collision_count: got %0d, required 0", reg_rdata);
      end
      reg_addr = 3'd6; #1;
      n_tests++;
      if (reg_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL collision_seq: got %h, required 00", reg_rdata);
      end
      repeat (6) step();
      tick = 1'b0;
   endtask

   task automatic test_period_update();
      wr(3'd1, 8'd3);
      wr(3'd3, 8'h01);
      w = cyc;
      push(w + 4, 0, 2'd0);
      push(w + 14, 0, 2'd1);
      push(w + 24, 0, 2'd2);
      tick = 1'b1;
      step();
      reg_addr = 3'd4; #1;
      n_tests++;
      if (reg_rdata !== 8'd2) begin
         n_fail++;
         $display("FAIL update_count_a: got %0d, required 2", reg_rdata);
      end
      wr(3'd1, 8'd9);
      reg_addr = 3'd4; #1;
      n_tests++;
      if (reg_rdata !== 8'd1) begin
         n_fail++;
         $display("FAIL update_count_b: got %0d, required 1", reg_rdata);
      end
      repeat (3) step();
      reg_addr = 3'd4; #1;
      n_tests++;
      if (reg_rdata !== 8'd8) begin
         n_fail++;
         $display("FAIL update_count_reload: got %0d, required 8", reg_rdata);
      end
      while (cyc < w + 26) step();
      wr(3'd3, 8'h00);
      tick = 1'b0;
   endtask

   task automatic test_reset_midcount();
      wr(3'd1, 8'd2);
      wr(3'd2, 8'd2);
      wr(3'd3, 8'h05);
      tick = 1'b1;
      repeat (2) step();
      reset     = 1'b1;
      reg_wr    = 1'b1;
      reg_addr  = 3'd0;
      reg_wdata = 8'h55;
      step();
      reset  = 1'b0;
      reg_wr = 1'b0;
      n_tests++;
      if ({timer1_trigger, timer2_trigger, timer1_address, timer2_address} !== 6'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %b, required 000000",
                  {timer1_trigger, timer2_trigger, timer1_address, timer2_address});
      end
      for (int a = 0; a < 7; a++) begin
         reg_addr = 3'(a);
         #1;
         n_tests++;
         if (reg_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_reg%0d: got %h, required 00", a, reg_rdata);
         end
      end
      repeat (10) step();
      tick = 1'b0;
   endtask

   task automatic test_simultaneous();
      wr(3'd3, 8'h05);
      w = cyc;
      for (int ch = 0; ch < 2; ch++) begin
         push(w + 1, ch, 2'd0);
         push(w + 2, ch, 2'd1);
         push(w + 3, ch, 2'd2);
         push(w + 4, ch, 2'd3);
         push(w + 5, ch, 2'd0);
         push(w + 6, ch, 2'd1);
         push(w + 8, ch, 2'd2);
      end
      tick = 1'b1;
      repeat (3) step();
      wr(3'd6, 8'hFF);
      repeat (2) step();
      wr(3'd0, 8'd0);
      step();
      wr(3'd3, 8'h00);
      tick = 1'b0;
      reg_addr = 3'd6; #1;
      n_tests++;
      if (reg_rdata !== 8'h0F) begin
         n_fail++;
         $display("FAIL simul_seq: got %h, required 0F", reg_rdata);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_queue: got %0d entries left, required 0", exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      tick      = 1'b1;
      reg_wr    = 1'b1;
      reg_addr  = 3'd3;
      reg_wdata = 8'h05;
      test_reset();
      test_periodic();
      test_oneshot();
      test_ctrl_collision();
      test_period_update();
      test_reset_midcount();
      test_simultaneous();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wts_timer_ctrl.md
WTS_TIMER_CTRL -- requirements
Module: wts_timer_ctrl

Interface
REQ-001 SHALL have parameter TIMER_W, default 8, width of the prescale, period and count registers (the register map below is defined for 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port tick, input, 1, one-cycle base time strobe (one per sample period).
REQ-005 SHALL have port reg_wr, input, 1, register write strobe.
REQ-006 SHALL have port reg_addr, input, 3, register select for both write and read.
REQ-007 SHALL have port reg_wdata, input, 8, write data.
REQ-008 SHALL have port reg_rdata, output, 8, combinational read data for reg_addr.
REQ-009 SHALL have ports timer1_trigger and timer2_trigger, output, 1 each, one-cycle expiry pulses feeding the interrupt/status block.
REQ-010 SHALL have ports timer1_address and timer2_address, output, 2 each, expiry sequence number, valid while the matching trigger is high.

Function
REQ-011 SHALL implement this register map: 0 prescale RW; 1 timer1 period RW; 2 timer2 period RW; 3 control RW, where bit0 = t1 run, bit1 = t1 one-shot, bit2 = t2 run, bit3 = t2 one-shot, and bits 7:4 read 0; 4 timer1 count RO; 5 timer2 count RO; 6 {4'b0, t2 addr, t1 addr} RO, where any write clears both addr counters; 7 reads 0 and ignores writes.
REQ-012 SHALL keep a prescale counter pre_cnt that advances only on tick; when tick=1 and pre_cnt==prescale, it SHALL raise internal base_tick for that cycle and set pre_cnt to 0, otherwise pre_cnt+1.
REQ-013 With prescale=0, base_tick SHALL equal tick.
REQ-014 A write to register 0 SHALL also clear pre_cnt, and no base_tick SHALL occur in that cycle.
REQ-015 Each timer SHALL be a down-counter cnt; on base_tick with run=1, cnt==0 is an expiry and cnt!=0 decrements it.
REQ-016 On expiry: the trigger SHALL be high in the next cycle, exactly 1 cycle wide; address SHALL be the pre-increment addr value; addr SHALL then increment mod 4 (3 wraps to 0).
REQ-017 On expiry in periodic mode (one-shot=0), cnt SHALL reload from period; in one-shot mode, run SHALL clear and cnt SHALL hold at 0.
REQ-018 Expiry period SHALL therefore be (period+1) base_ticks; period=0 SHALL expire on every base_tick.
REQ-019 A control write with run=1 SHALL load cnt from the current period register value, whether the timer was stopped or running (restart).
REQ-020 A control write with run=0 SHALL stop the timer and hold cnt.
REQ-021 A period write SHALL NOT alter cnt; the new value takes effect at the next reload or start.
REQ-022 A control write in the same cycle as an expiry SHALL win: no trigger, no addr increment, and the write's load/stop applies.
REQ-023 A register 6 write in the same cycle as an expiry SHALL clear addr; the trigger SHALL still fire with the pre-clear address.
REQ-024 Both timers SHALL be independent and MAY trigger in the same cycle.
REQ-025 Triggers and addresses SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-026 While reset=1: prescale, periods, cnt, pre_cnt and addr SHALL be 0; run and one-shot SHALL be 0; triggers SHALL be 0 and addresses 2'b00.
REQ-027 Reset SHALL override any concurrent reg_wr or tick; an expiry in flight when reset asserts SHALL produce no trigger.

Structure
REQ-028 The register address constants and control-bit positions SHALL live in a shared package (wts_timer_pkg) used by this block and the bus decoder.
REQ-029 The per-timer counter/reload/addr logic SHALL be one sub-module, wts_timer_channel, instantiated twice; the prescaler and register file stay in the top.

Verification
REQ-030 Setup: prescale=0, period1=3, control=0x01, tick every cycle -> timer1_trigger every 4 cycles with address 0,1,2,3,0; timer2 silent.
REQ-031 Setup: prescale=2, period2=1, control=0x0C, tick every cycle -> exactly one timer2_trigger, 6 ticks after the write; afterwards run2 reads 0 and count reads 0.
REQ-032 Force a control=0x00 write in the cycle cnt1==0 and base_tick is high -> no trigger; count1 holds 0; addr1 is unchanged.
REQ-033 Write period1=9 while running with period 3 -> the next interval is still 4; the following intervals are 10; reading reg 4 shows the decrementing count.
REQ-034 Assert reset for 1 cycle mid-count, with both timers running and a pending expiry -> all outputs 0, reg_rdata 0 for addresses 0-6, and no trigger afterwards until the registers are reprogrammed.
REQ-035 Set period1=period2=0, control=0x05 -> both triggers high in the same cycles; a write to reg 6 coincident with an expiry -> trigger address pre-clear, and the next address is 0.
